// File: rtl/filter_stream_ctrl_if.sv
// Pixel stream bundle: input stream (s_axis_*) and output stream (m_axis_*).
// slave = the controller's view, master = the upstream/downstream environment.
interface filter_stream_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;
  logic                  s_axis_tuser;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  m_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );
endinterface

// File: rtl/filter_stream_ctrl.sv
// Stream controller for a line-buffered window filter: paces the datapath, flushes it
// at end of frame and regenerates output framing. state | meaning:
//   IDLE | wait for tuser  RUN | accept frame pixels  FLUSH | drain D zero advances
module filter_stream_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int WINDOW_SIZE  = 3,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 512,
  parameter int PIPE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  filter_stream_ctrl_if.slave   axis,
  output logic                  pipe_en,
  output logic [DATA_WIDTH-1:0] pipe_din,
  input  logic [DATA_WIDTH-1:0] pipe_dout,
  output logic                  m_border,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int R     = WINDOW_SIZE / 2;
  localparam int D     = R * FRAME_WIDTH + R + PIPE_LATENCY;
  localparam int NPIX  = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int COL_W = $clog2(FRAME_WIDTH);
  localparam int ROW_W = $clog2(FRAME_HEIGHT);
  localparam int ADV_W = $clog2(NPIX + D + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LO   = COL_W'(R);
  localparam logic [COL_W-1:0] COL_HI   = COL_W'(FRAME_WIDTH - 1 - R);
  localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(R);
  localparam logic [ROW_W-1:0] ROW_HI   = ROW_W'(FRAME_HEIGHT - 1 - R);
  localparam logic [ADV_W-1:0] ADV_D    = ADV_W'(D);
  localparam logic [ADV_W-1:0] ADV_END  = ADV_W'(NPIX + D);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADV_W-1:0]      r_adv_cnt;
  logic [COL_W-1:0]      r_in_col, r_out_col;
  logic [ROW_W-1:0]      r_in_row, r_out_row;
  logic                  r_m_tvalid, r_frame_err;
  logic                  w_s_tready, w_pipe_en, w_s_acc, w_m_xfer, w_m_free;
  logic                  w_take_sof, w_in_last, w_out_last;
  logic [DATA_WIDTH-1:0] w_pipe_din;

  assign w_m_free   = !r_m_tvalid | axis.m_axis_tready;
  assign w_m_xfer   = r_m_tvalid & axis.m_axis_tready;
  assign w_s_acc    = axis.s_axis_tvalid & w_s_tready;
  assign w_take_sof = (r_state == S_IDLE) & axis.s_axis_tvalid & axis.s_axis_tuser;
  assign w_in_last  = (r_in_col == COL_LAST) & (r_in_row == ROW_LAST);
  assign w_out_last = (r_out_col == COL_LAST) & (r_out_row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_take_sof) w_state_nxt = S_RUN;
      S_RUN:   if (w_s_acc && w_in_last) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_m_xfer && w_out_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_s_tready = 1'b1;
    w_pipe_en  = 1'b0;
    w_pipe_din = axis.s_axis_tdata;
    case (r_state)
      S_IDLE:  w_pipe_en = axis.s_axis_tvalid & axis.s_axis_tuser;
      S_RUN: begin
        w_s_tready = w_m_free;
        w_pipe_en  = axis.s_axis_tvalid & w_m_free;
      end
      S_FLUSH: begin
        w_s_tready = 1'b0;
        w_pipe_din = '0;
        w_pipe_en  = w_m_free & (r_adv_cnt != ADV_END);
      end
      default: ;
    endcase
  end

  // Counters restart on the tuser beat, which is itself pixel 0 and advance 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adv_cnt   <= '0;
      r_in_col    <= '0;
      r_in_row    <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_m_tvalid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_take_sof) begin
        r_adv_cnt <= ADV_W'(1);
        r_in_col  <= COL_W'(1);
        r_in_row  <= '0;
        r_out_col <= '0;
        r_out_row <= '0;
      end else begin
        if (w_pipe_en) r_adv_cnt <= r_adv_cnt + 1'b1;
        if (r_state == S_RUN && w_s_acc) begin
          if ((axis.s_axis_tlast != (r_in_col == COL_LAST)) || axis.s_axis_tuser)
            r_frame_err <= 1'b1;
          if (r_in_col == COL_LAST) begin
            r_in_col <= '0;
            r_in_row <= (r_in_row == ROW_LAST) ? '0 : r_in_row + 1'b1;
          end else begin
            r_in_col <= r_in_col + 1'b1;
          end
        end
        if (w_m_xfer) begin
          if (r_out_col == COL_LAST) begin
            r_out_col <= '0;
            r_out_row <= (r_out_row == ROW_LAST) ? '0 : r_out_row + 1'b1;
          end else begin
            r_out_col <= r_out_col + 1'b1;
          end
        end
      end
      if (w_pipe_en && r_state != S_IDLE && r_adv_cnt >= ADV_D) r_m_tvalid <= 1'b1;
      else if (axis.m_axis_tready)                                r_m_tvalid <= 1'b0;
    end
  end

  assign axis.s_axis_tready = w_s_tready;
  assign axis.m_axis_tdata  = pipe_dout;
  assign axis.m_axis_tvalid = r_m_tvalid;
  assign axis.m_axis_tlast  = r_m_tvalid & (r_out_col == COL_LAST);
  assign axis.m_axis_tuser  = r_m_tvalid & (r_out_col == '0) & (r_out_row == '0);
  assign pipe_en   = w_pipe_en & rst_n;
  assign pipe_din  = w_pipe_din;
  assign m_border  = (r_out_col < COL_LO) | (r_out_col > COL_HI) |
                     (r_out_row < ROW_LO) | (r_out_row > ROW_HI);
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Directed bench for filter_stream_ctrl on an 8x4 frame, window 3, latency 2 (D = 11).
// The datapath is stood in for by a D+1 deep shift register clocked by pipe_en.
module tb_filter_stream_ctrl;
  localparam int DW = 8, W = 8, H = 4, WS = 3, PL = 2;
  localparam int R = WS / 2, D = R * W + R + PL, NPIX = W * H;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  filter_stream_ctrl_if #(.DATA_WIDTH(DW)) axis ();
  logic          pipe_en, m_border, frame_err, busy;
  logic [DW-1:0] pipe_din, pipe_dout;
  logic [DW-1:0] sr [0:D];

  filter_stream_ctrl #(.DATA_WIDTH(DW), .WINDOW_SIZE(WS), .FRAME_WIDTH(W),
                       .FRAME_HEIGHT(H), .PIPE_LATENCY(PL)) u_dut (
    .clk(clk), .rst_n(rst_n), .axis(axis), .pipe_en(pipe_en), .pipe_din(pipe_din),
    .pipe_dout(pipe_dout), .m_border(m_border), .frame_err(frame_err), .busy(busy));

  always @(posedge clk) if (pipe_en) begin
    sr[0] <= pipe_din;
    for (int j = 1; j <= D; j++) sr[j] <= sr[j-1];
  end
  assign pipe_dout = sr[D];

  int vectors = 0, miscompares = 0;
  int cyc = 0, smp_cyc, out_n = 0, fr_mon = 0;
  int first_cyc [0:7];
  int sof_cyc   [0:7];
  bit seen_first = 0, stall_prev = 0, rand_rdy = 0;
  logic [DW-1:0] prev_data;
  logic smp_tready, smp_busy, smp_ferr, smp_pipe_en, smp_tvalid;

  function automatic logic [DW-1:0] pix(input int f, input int k);
    return DW'(f * 40 + 3 + k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout, expected completion", tag);
  endtask

  // One clock: sample and score outputs at negedge, then drive tready after posedge.
  task automatic step();
    int col, row;
    @(negedge clk);
    smp_cyc = cyc; smp_tready = axis.s_axis_tready; smp_busy = busy;
    smp_ferr = frame_err; smp_pipe_en = pipe_en; smp_tvalid = axis.m_axis_tvalid;
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_hold_valid", 32'(axis.m_axis_tvalid), 32'd1);
        check("stall_hold_data", 32'(axis.m_axis_tdata), 32'(prev_data));
      end
      if (axis.m_axis_tvalid && !seen_first) begin
        first_cyc[fr_mon] = cyc;
        seen_first = 1;
      end
      if (axis.m_axis_tvalid && !axis.m_axis_tready)
        check("stall_pipe_en", 32'(pipe_en), 32'd0);
      if (axis.m_axis_tvalid && axis.m_axis_tready) begin
        col = out_n % W;
        row = out_n / W;
        check($sformatf("out_data[f%0d,%0d]", fr_mon, out_n), 32'(axis.m_axis_tdata), 32'(pix(fr_mon, out_n)));
        check($sformatf("out_tlast[%0d]", out_n), 32'(axis.m_axis_tlast), 32'(col == W - 1));
        check($sformatf("out_tuser[%0d]", out_n), 32'(axis.m_axis_tuser), 32'(out_n == 0));
        check($sformatf("out_border[%0d]", out_n), 32'(m_border),
              32'((col < R) || (col > W - 1 - R) || (row < R) || (row > H - 1 - R)));
        out_n++;
        if (out_n == NPIX) begin
          out_n = 0;
          fr_mon++;
          seen_first = 0;
        end
      end
      stall_prev = axis.m_axis_tvalid && !axis.m_axis_tready;
      prev_data  = axis.m_axis_tdata;
    end
    @(posedge clk);
    cyc++;
    #1;
    axis.m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_frame(input int f, input bit gaps, input int err_idx,
                            input int abort_out, input bit expect_wait);
    bit acc, chk_err;
    int n;
    chk_err = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        axis.s_axis_tvalid = 1'b0;
        step();
      end
      axis.s_axis_tvalid = 1'b1;
      axis.s_axis_tdata  = pix(f, i);
      axis.s_axis_tlast  = ((i % W) == W - 1) || (i == err_idx);
      axis.s_axis_tuser  = (i == 0);
      acc = 0;
      n = 0;
      while (!acc) begin
        step();
        if (abort_out > 0 && out_n >= abort_out) begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_m_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
          check("rst_m_tlast", 32'(axis.m_axis_tlast), 32'd0);
          check("rst_m_tuser", 32'(axis.m_axis_tuser), 32'd0);
          check("rst_s_tready", 32'(axis.s_axis_tready), 32'd1);
          check("rst_pipe_en", 32'(pipe_en), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_frame_err", 32'(frame_err), 32'd0);
          axis.s_axis_tvalid = 1'b0; axis.s_axis_tuser = 1'b0; axis.s_axis_tlast = 1'b0;
          if (out_n != 0) fr_mon++;
          out_n = 0; seen_first = 0; stall_prev = 0;
          step(); step();
          rst_n = 1'b1;
          repeat (4) step();
          check("no_out_after_rst", 32'(smp_tvalid), 32'd0);
          return;
        end
        if (chk_err) begin
          check("frame_err_set", 32'(smp_ferr), 32'd1);
          chk_err = 0;
        end
        if (i == err_idx) check("frame_err_before", 32'(smp_ferr), 32'd0);
        if (i == 0 && expect_wait && n == 0) begin
          check("flush_tready", 32'(smp_tready), 32'd0);
          check("flush_busy", 32'(smp_busy), 32'd1);
        end
        acc = smp_tready;
        if (acc && i == 0) sof_cyc[f] = smp_cyc;
        n++;
        if (!acc && n > 300) begin
          timeout($sformatf("accept_timeout[f%0d,%0d]", f, i));
          axis.s_axis_tvalid = 1'b0;
          return;
        end
      end
      if (i == err_idx) chk_err = 1;
    end
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tuser  = 1'b0;
    axis.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int f, input bit chk_idle);
    int n = 0;
    while (fr_mon <= f && n < 3000) begin
      step();
      n++;
    end
    if (fr_mon <= f) timeout($sformatf("frame_done_timeout[f%0d]", f));
    else if (chk_idle) begin
      step();
      check("busy_after_last", 32'(smp_busy), 32'd0);
      check("tvalid_after_last", 32'(smp_tvalid), 32'd0);
    end
  endtask

  initial begin
    axis.s_axis_tvalid = 1'b0; axis.s_axis_tdata = '0;
    axis.s_axis_tlast  = 1'b0; axis.s_axis_tuser = 1'b0;
    axis.m_axis_tready = 1'b1;
    #2 rst_n = 1'b0;
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tuser  = 1'b1;
    #1;
    check("reset_m_tvalid", 32'(axis.m_axis_tvalid), 32'd0);
    check("reset_m_tlast", 32'(axis.m_axis_tlast), 32'd0);
    check("reset_m_tuser", 32'(axis.m_axis_tuser), 32'd0);
    check("reset_s_tready", 32'(axis.s_axis_tready), 32'd1);
    check("reset_pipe_en", 32'(pipe_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tuser  = 1'b0;
    rst_n = 1'b1;
    step(); step();

    // full-rate frame
    send_frame(0, 0, -1, 0, 0);
    wait_done(0, 1);
    check("latency_f0", 32'(first_cyc[0] - sof_cyc[0]), 32'd12);

    // random output stalls and input gaps
    rand_rdy = 1;
    send_frame(1, 1, -1, 0, 0);
    wait_done(1, 1);
    rand_rdy = 0;
    step();

    // junk beats before the start of frame are swallowed
    for (int i = 0; i < 5; i++) begin
      axis.s_axis_tvalid = 1'b1;
      axis.s_axis_tuser  = 1'b0;
      axis.s_axis_tdata  = DW'(8'hE0 + i);
      step();
      check($sformatf("junk_tready[%0d]", i), 32'(smp_tready), 32'd1);
      check($sformatf("junk_pipe_en[%0d]", i), 32'(smp_pipe_en), 32'd0);
    end
    send_frame(2, 0, -1, 0, 0);
    wait_done(2, 1);

    // next frame's tuser presented while the previous one flushes
    send_frame(3, 0, -1, 0, 0);
    send_frame(4, 0, -1, 0, 1);
    wait_done(4, 1);
    check("latency_f4", 32'(first_cyc[4] - sof_cyc[4]), 32'd12);

    // tlast on input column 5 of line 1
    send_frame(5, 0, W + 5, 0, 0);
    wait_done(5, 1);
    check("frame_err_sticky", 32'(frame_err), 32'd1);

    // reset during output beat 17, then a clean frame
    send_frame(6, 0, -1, 17, 0);
    send_frame(7, 0, -1, 0, 0);
    wait_done(7, 1);
    check("latency_f7", 32'(first_cyc[7] - sof_cyc[7]), 32'd12);
    check("frame_err_clean", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/filter_stream_ctrl.md
FILTER_STREAM_CTRL -- requirements
Module: filter_stream_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 8, pixel width.
- WINDOW_SIZE, 3, odd filter window edge.
- FRAME_WIDTH, 640, pixels per line.
- FRAME_HEIGHT, 512, lines per frame.
- PIPE_LATENCY, 4, datapath register stages after the window is formed.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- s_axis_tdata, in, DATA_WIDTH, input pixel.
- s_axis_tvalid, in, 1, input beat valid.
- s_axis_tready, out, 1, input beat accepted.
- s_axis_tlast, in, 1, end of line.
- s_axis_tuser, in, 1, start of frame.
- m_axis_tdata, out, DATA_WIDTH, output pixel, equal to pipe_dout.
- m_axis_tvalid, out, 1, output beat valid.
- m_axis_tready, in, 1, downstream ready.
- m_axis_tlast, out, 1, end of output line.
- m_axis_tuser, out, 1, first output pixel of frame.
- pipe_en, out, 1, advance enable for the line buffers and adder tree.
- pipe_din, out, DATA_WIDTH, datapath input.
- pipe_dout, in, DATA_WIDTH, datapath result.
- m_border, out, 1, current output pixel lies within R = WINDOW_SIZE/2 of any frame edge.
- frame_err, out, 1, sticky framing error.
- busy, out, 1, state is not IDLE.

Function
REQ-003 D SHALL equal R*FRAME_WIDTH + R + PIPE_LATENCY: the number of pipe_en advances from a pixel entering to its centred result appearing on pipe_dout.
REQ-004 The FSM SHALL have states IDLE, RUN and FLUSH.
REQ-005 IDLE: s_axis_tready=1; beats without tuser SHALL be discarded (pipe_en=0); a beat with tvalid&tuser SHALL be taken as pixel 0 of the frame, assert pipe_en and move to RUN.
REQ-006 RUN: s_axis_tready SHALL equal (!m_axis_tvalid | m_axis_tready).
REQ-007 In RUN, pipe_en SHALL equal s_axis_tvalid & s_axis_tready.
REQ-008 RUN SHALL go to FLUSH on acceptance of beat number FRAME_WIDTH*FRAME_HEIGHT-1.
REQ-009 FLUSH: s_axis_tready=0 and pipe_din=0; pipe_en SHALL equal (!m_axis_tvalid | m_axis_tready).
REQ-010 FLUSH SHALL return to IDLE after D advances, with the last output beat transferred.
REQ-011 In RUN and IDLE, pipe_din SHALL equal s_axis_tdata.
REQ-012 Advance counter adv_cnt SHALL count pipe_en pulses within a frame, cleared on the tuser beat taken in IDLE.
REQ-013 m_axis_tvalid SHALL be registered: set on the cycle after a pipe_en with adv_cnt >= D (counted before increment), and cleared on the cycle after m_axis_tready when no such pipe_en occurs.
REQ-014 m_axis_tvalid SHALL never be lowered while m_axis_tready=0; m_axis_tdata SHALL hold stable under stall because pipe_en=0.
REQ-015 Exactly FRAME_WIDTH*FRAME_HEIGHT output beats SHALL be emitted per frame.
REQ-016 Output column and row counters SHALL advance on each output transfer: column wraps at FRAME_WIDTH-1, row wraps at FRAME_HEIGHT-1.
REQ-017 m_axis_tlast SHALL be 1 iff column = FRAME_WIDTH-1; m_axis_tuser SHALL be 1 iff column = 0 and row = 0.
REQ-018 Both SHALL be qualified by m_axis_tvalid.
REQ-019 m_border SHALL be 1 iff col<R, col>FRAME_WIDTH-1-R, row<R or row>FRAME_HEIGHT-1-R.
REQ-020 Framing is count-based. In RUN, s_axis_tlast disagreeing with input column=FRAME_WIDTH-1 on an accepted beat SHALL set frame_err.
REQ-021 s_axis_tuser=1 on a non-first accepted beat SHALL set frame_err.
REQ-022 The beat SHALL otherwise be treated as a normal pixel; frame_err SHALL clear only on reset.
REQ-023 A tuser beat presented during FLUSH SHALL wait (tready=0) and be taken in IDLE.
REQ-024 Counter widths SHALL be $clog2(max+1); a counter SHALL never wrap inside a frame.

Reset
REQ-025 While rst_n=0, independent of clk:
- state = IDLE.
- All counters = 0.
- m_axis_tvalid, m_axis_tlast, m_axis_tuser, pipe_en, frame_err, busy = 0.
- s_axis_tready = 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without emitting further beats.
REQ-027 After reset release the block SHALL wait for a fresh tuser.

Verification (W=8, H=4, WS=3, PIPE_LATENCY=2, so D=11)
REQ-028 Full-rate frame of 32 beats, tready=1: exactly 32 outputs, in order; first m_axis_tvalid 12 cycles after the tuser beat; tlast on outputs 7, 15, 23, 31; tuser on output 0; busy falls after the last transfer.
REQ-029 Random m_axis_tready (50%) and tvalid gaps: output sequence identical to full rate; no data change while tvalid&!tready; pipe_en=0 on every stalled cycle.
REQ-030 Junk beats before tuser: 5 beats with tuser=0 accepted and dropped (pipe_en=0); frame then starts normally.
REQ-031 tlast on input column 5 of line 1: frame_err=1 from the next cycle; still 32 outputs with correct output tlast positions.
REQ-032 Next frame's tuser asserted during FLUSH: s_axis_tready=0 until IDLE; frame 2 output is back-to-back and correct.
REQ-033 rst_n pulled low at output beat 17: all outputs 0 and tready=1 asynchronously; next frame fully correct.
